cgram_loader: RTL and testbench
===============================

# cgram_loader

Parametrised CGRAM glyph loader for the HD44780-style character LCD path. On a start pulse it emits a set-CGRAM-address command, then one write command per glyph row read from an internal glyph ROM, then an optional return-to-DDRAM command. Commands go to the LCD command driver over a valid/ready handshake. A sticky `done` flag gates the downstream text writer.

## Interface
- `NUM_GLYPHS`, default 8: number of glyphs to load, 1..64/GLYPH_ROWS.
- `GLYPH_ROWS`, default 8: rows per glyph. 8 selects 5x8 font; 16 selects 5x10 font (max 4 glyphs).
- `BASE_GLYPH`, default 0: first CGRAM glyph slot. Requires BASE_GLYPH+NUM_GLYPHS ≤ 64/GLYPH_ROWS; a violation is an elaboration error.
- `RETURN_DDRAM`, default 1: 1 appends a SETAD command with data 8'h00 after the last row.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle load request.
- `cmd_ready` in 1: driver can accept a command.
- `cmd_valid` out 1: `cmd_data` holds a command.
- `cmd_data` out 12: {opcode[3:0], data[7:0]}.
- `busy` out 1: a load is in progress.
- `done` out 1: the last load completed. Held until the next accepted start or reset.

## Operation
- Opcodes: CLEAR=4'h0, WRITE=4'h1, SETCG=4'h2, SETAD=4'h3, WAIT=4'hF.
- A transfer happens on a rising edge with `cmd_valid` and `cmd_ready` both high.
- While `cmd_valid` is high and `cmd_ready` is low, `cmd_data` stays stable.
- FSM states: IDLE, SET_CG, FETCH, WRITE, SET_DD, DONE.
- IDLE/DONE: `cmd_valid`=0, `cmd_data`={WAIT,8'h00}. On `start`, go to SET_CG, clear `done`, set `busy`.
- SET_CG: `cmd_data`={SETCG, 2'b00, BASE_GLYPH*GLYPH_ROWS (6 bits)}. On transfer, row counter ← 0 and go to FETCH.
- FETCH: ROM read issued at address row counter + BASE_GLYPH*GLYPH_ROWS. Go to WRITE.
- WRITE: `cmd_data`={WRITE, 3'b000, rom_data[4:0]}. Upper 3 bits are forced to 0.
- On a WRITE transfer:
  - if row counter = NUM_GLYPHS*GLYPH_ROWS−1, go to SET_DD (RETURN_DDRAM=1) or DONE;
  - otherwise increment the row counter and go to FETCH.
- SET_DD: `cmd_data`={SETAD,8'h00}. On transfer go to DONE.
- DONE: `done`=1, `busy`=0.
- Row counter is 7 bits; it never wraps within a load.
- `start` while `busy`=1 is ignored. No queueing.
- `start` in DONE restarts a full load.

## Timing
- Reset values: `cmd_valid`=0, `cmd_data`=12'hF00, `busy`=0, `done`=0, FSM=IDLE, row counter=0.
- Reset asserted mid-load aborts at once. No further transfers. The next load begins at SET_CG.
- `start` sampled at cycle 0 gives `cmd_valid`=1 in cycle 1.
- Each row costs 2 cycles minimum (FETCH + WRITE). ROM read latency is 1 cycle.
- With `cmd_ready` held at 1 and defaults:
  - SETCG at cycle 1;
  - row i WRITE at cycle 3+2i;
  - last WRITE at cycle 129;
  - SETAD at cycle 130;
  - `done`=1 from cycle 131.
  - Total: 66 transfers.
- `cmd_ready` low stalls the FSM in its current state. It adds exactly the stall cycles to the latency.
- Reset asserted in the same cycle as `start`: reset wins.

## Structure
- Shared package `lcd_cmd_pkg`: opcode constants, the 12-bit command typedef, and CGRAM address-width constants. The LCD command driver and the text writer share these.
- Sub-module `cgram_glyph_rom` (parameter GLYPH_ROWS):
  - 6-bit address in, registered 5-bit row out;
  - holds the team's standard 8-glyph 5x8 bitmap set;
  - rows past a defined glyph read 0.
- The FSM and counter stay in `cgram_loader`.

## Test plan
- Defaults, `cmd_ready`=1, single `start` -> 66 transfers: first 12'h200, then 64 WRITEs matching the ROM, last 12'h300. `done` rises at cycle 131.
- Random `cmd_ready` backpressure (50%) -> identical transfer sequence. `cmd_data` is stable on every stalled cycle. No duplicated or dropped rows.
- BASE_GLYPH=2, NUM_GLYPHS=2 -> SETCG data 8'h10, then 16 WRITEs of ROM rows 16..31, then SETAD.
- GLYPH_ROWS=16, NUM_GLYPHS=4, RETURN_DDRAM=0 -> SETCG 12'h200, then 64 WRITEs, no SETAD, `done` at cycle 130.
- `rst_n` pulsed low after the 20th transfer -> all outputs return to reset values immediately. A new `start` replays from SETCG.
- `start` pulsed during a load -> ignored. `start` after `done` -> `done` clears next cycle and a full sequence repeats.

Source files
------------

// File: rtl/lcd_cmd_pkg.sv
// Shared LCD command definitions: opcodes, the 12-bit command word and CGRAM geometry.
// Used by the CGRAM loader, the LCD command driver and the text writer.
package lcd_cmd_pkg;

  localparam logic [3:0] OP_CLEAR = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_SETCG = 4'h2;
  localparam logic [3:0] OP_SETAD = 4'h3;
  localparam logic [3:0] OP_WAIT  = 4'hF;

  localparam int CGRAM_AW   = 6;
  localparam int CGRAM_ROWS = 64;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] data;
  } lcd_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_CG,
    ST_FETCH,
    ST_WRITE,
    ST_SET_DD,
    ST_DONE
  } cgl_state_e;

  localparam lcd_cmd_t CMD_IDLE = '{op: OP_WAIT, data: 8'h00};

  function automatic lcd_cmd_t mk_cmd(input logic [3:0] op, input logic [7:0] data);
    return '{op: op, data: data};
  endfunction

endpackage

// File: rtl/cgram_loader_if.sv
// Command channel from the CGRAM loader to the LCD command driver.
// Handshake: a command moves on a rising edge where cmd_valid and cmd_ready are both high;
// once cmd_valid rises, cmd_data holds steady and cmd_valid stays high until that edge.
interface cgram_loader_if;
  import lcd_cmd_pkg::*;

  logic     cmd_valid;
  logic     cmd_ready;
  lcd_cmd_t cmd_data;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);

endinterface

// File: rtl/cgram_glyph_rom.sv
// Standard 8-glyph 5x8 bitmap set with a registered 5-bit row output.
// In 5x10 mode each glyph occupies 16 addresses; rows 8..15 read as zero.
module cgram_glyph_rom #(
  parameter int GLYPH_ROWS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_en,
  input  logic [5:0] addr,
  output logic [4:0] row_data
);

  // One byte per row, row 0 in the least significant byte.
  localparam logic [63:0] GLYPHS [8] = '{
    64'h0000_040E_1F1F_0A00,  // heart
    64'h0000_000E_1100_0A00,  // smiley
    64'h0004_001F_0E0E_0E04,  // bell
    64'h0004_0404_0415_0E04,  // arrow up
    64'h0004_0E15_0404_0404,  // arrow down
    64'h001F_1111_1111_111F,  // box
    64'h0000_081C_1603_0100,  // check mark
    64'h1F1F_1F1F_1F1F_1F1F   // full block
  };

  logic [2:0] glyph;
  logic [3:0] row;
  logic [4:0] rd_val;

  always_comb begin
    glyph  = addr[5:3];
    row    = {1'b0, addr[2:0]};
    if (GLYPH_ROWS == 16) begin
      glyph = {1'b0, addr[5:4]};
      row   = addr[3:0];
    end
    rd_val = row[3] ? 5'd0 : GLYPHS[glyph][{row[2:0], 3'b000} +: 5];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     row_data <= 5'd0;
    else if (rd_en) row_data <= rd_val;
  end

endmodule

// File: rtl/cgram_loader.sv
// Loads glyph bitmaps into HD44780 CGRAM: SETCG, one WRITE per glyph row, optional SETAD.
// done stays high after a load until the next accepted start, gating the text writer.
module cgram_loader import lcd_cmd_pkg::*; #(
  parameter int NUM_GLYPHS   = 8,
  parameter int GLYPH_ROWS   = 8,
  parameter int BASE_GLYPH   = 0,
  parameter int RETURN_DDRAM = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  cgram_loader_if.master        cmd,
  output logic                  busy,
  output logic                  done,
  output cgl_state_e            state_dbg
);

  if ((GLYPH_ROWS != 8 && GLYPH_ROWS != 16) || NUM_GLYPHS < 1 || BASE_GLYPH < 0 ||
      BASE_GLYPH + NUM_GLYPHS > CGRAM_ROWS / GLYPH_ROWS) begin : g_bad_cfg
    $error("cgram_loader: glyph range does not fit in CGRAM");
  end

  localparam logic [6:0] LAST_ROW  = 7'(NUM_GLYPHS * GLYPH_ROWS - 1);
  localparam logic [5:0] BASE_ADDR = 6'(BASE_GLYPH * GLYPH_ROWS);

  cgl_state_e state;
  logic [6:0] row_cnt;
  logic       valid_q;
  lcd_cmd_t   cmd_q;
  logic [4:0] rom_q;
  logic       xfer;

  cgram_glyph_rom #(.GLYPH_ROWS(GLYPH_ROWS)) u_rom (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (state == ST_FETCH),
    .addr     (row_cnt[5:0] + BASE_ADDR),
    .row_data (rom_q)
  );

  assign xfer      = valid_q && cmd.cmd_ready;
  assign cmd.cmd_valid = valid_q;
  // In WRITE the payload comes straight from the ROM output register, which only
  // reloads in FETCH and therefore holds through any stall.
  assign cmd.cmd_data  = (state == ST_WRITE) ? mk_cmd(OP_WRITE, {3'b000, rom_q}) : cmd_q;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      row_cnt <= 7'd0;
      valid_q <= 1'b0;
      cmd_q   <= CMD_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_SET_CG;
            valid_q <= 1'b1;
            cmd_q   <= mk_cmd(OP_SETCG, {2'b00, BASE_ADDR});
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        ST_SET_CG: begin
          if (xfer) begin
            state   <= ST_FETCH;
            row_cnt <= 7'd0;
            valid_q <= 1'b0;
            cmd_q   <= CMD_IDLE;
          end
        end
        ST_FETCH: begin
          state   <= ST_WRITE;
          valid_q <= 1'b1;
        end
        ST_WRITE: begin
          if (xfer) begin
            valid_q <= 1'b0;
            if (row_cnt != LAST_ROW) begin
              state   <= ST_FETCH;
              row_cnt <= row_cnt + 7'd1;
            end else if (RETURN_DDRAM != 0) begin
              state   <= ST_SET_DD;
              valid_q <= 1'b1;
              cmd_q   <= mk_cmd(OP_SETAD, 8'h00);
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_SET_DD: begin
          if (xfer) begin
            state   <= ST_DONE;
            valid_q <= 1'b0;
            cmd_q   <= CMD_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
          cmd_q   <= CMD_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cgram_loader.sv
// Directed bench for cgram_loader: three parameterisations side by side, each load
// checked transfer-by-transfer against an expected queue built from a hand-written glyph table.
module tb_cgram_loader;
  import lcd_cmd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0] start_v;
  logic [2:0] rdy_v;
  wire  [2:0] val_v;
  wire  [2:0] busy_v;
  wire  [2:0] done_v;
  wire  [11:0] dat_v [3];
  cgl_state_e st0, st1, st2;

  cgram_loader_if if0 ();
  cgram_loader_if if1 ();
  cgram_loader_if if2 ();

  assign if0.cmd_ready = rdy_v[0];
  assign if1.cmd_ready = rdy_v[1];
  assign if2.cmd_ready = rdy_v[2];
  assign val_v = {if2.cmd_valid, if1.cmd_valid, if0.cmd_valid};
  assign dat_v[0] = if0.cmd_data;
  assign dat_v[1] = if1.cmd_data;
  assign dat_v[2] = if2.cmd_data;

  cgram_loader #(.NUM_GLYPHS(8), .GLYPH_ROWS(8), .BASE_GLYPH(0), .RETURN_DDRAM(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .cmd(if0.master),
    .busy(busy_v[0]), .done(done_v[0]), .state_dbg(st0));

  cgram_loader #(.NUM_GLYPHS(2), .GLYPH_ROWS(8), .BASE_GLYPH(2), .RETURN_DDRAM(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .cmd(if1.master),
    .busy(busy_v[1]), .done(done_v[1]), .state_dbg(st1));

  cgram_loader #(.NUM_GLYPHS(4), .GLYPH_ROWS(16), .BASE_GLYPH(0), .RETURN_DDRAM(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .cmd(if2.master),
    .busy(busy_v[2]), .done(done_v[2]), .state_dbg(st2));

  int cfg_base [3] = '{0, 2, 0};
  int cfg_ng   [3] = '{8, 2, 4};
  int cfg_rows [3] = '{8, 8, 16};
  int cfg_dd   [3] = '{1, 1, 0};

  logic [4:0] glyph_tab [64];

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] model_row(input int rows, input int a);
    if (rows == 8) return glyph_tab[a];
    if ((a % 16) >= 8) return 5'd0;
    return glyph_tab[(a / 16) * 8 + (a % 16)];
  endfunction

  task automatic build_exp(input int d);
    int base_addr;
    base_addr = cfg_base[d] * cfg_rows[d];
    exp_q.delete();
    exp_q.push_back(12'h200 | 12'(base_addr));
    for (int i = 0; i < cfg_ng[d] * cfg_rows[d]; i++)
      exp_q.push_back({4'h1, 3'b000, model_row(cfg_rows[d], base_addr + i)});
    if (cfg_dd[d] != 0) exp_q.push_back(12'h300);
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, "_valid"}, 32'(val_v[d]), 0);
    check({tag, "_data"},  32'(dat_v[d]), 32'h F00);
    check({tag, "_busy"},  32'(busy_v[d]), 0);
    check({tag, "_done"},  32'(done_v[d]), 0);
  endtask

  // ---------------- driver ----------------
  // One load on DUT d. bp: random cmd_ready; abort_at: reset after that many transfers;
  // mid_start_at: cycle at which a stray start pulse is sent during the load.
  task automatic run_load(input int d, input bit bp, input int abort_at, input int mid_start_at);
    int cyc, xfers, stalls, done_cyc, rows, exp_done;
    bit ended, aborted, was_stall;
    logic [11:0] held;
    cyc = 0; xfers = 0; stalls = 0; done_cyc = 0;
    ended = 0; aborted = 0; was_stall = 0; held = '0;
    rows = cfg_ng[d] * cfg_rows[d];
    exp_done = 1 + 2 * rows + ((cfg_dd[d] != 0) ? 2 : 1);
    build_exp(d);

    @(posedge clk); #1;
    rdy_v[d]   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    rdy_v[d]   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 1;

    while (!ended && !aborted && cyc < 600) begin
      @(negedge clk);
      if (cyc == 1) begin
        check("busy_c1", 32'(busy_v[d]), 1);
        check("done_c1", 32'(done_v[d]), 0);
      end
      if (was_stall) begin
        check("stall_valid", 32'(val_v[d]), 1);
        check("stall_data", 32'(dat_v[d]), 32'(held));
      end
      if (done_v[d]) begin
        done_cyc = cyc;
        ended = 1;
      end else if (val_v[d] && rdy_v[d]) begin
        if (exp_q.size() == 0) check("extra_xfer", 32'(dat_v[d]), 32'h FFFF_FFFF);
        else check("xfer", 32'(dat_v[d]), 32'(exp_q.pop_front()));
        xfers++;
      end
      was_stall = val_v[d] && !rdy_v[d];
      if (was_stall) begin
        stalls++;
        held = dat_v[d];
      end
      if (!ended) begin
        @(posedge clk); #1;
        if (abort_at > 0 && xfers == abort_at) begin
          aborted = 1;
        end else begin
          cyc++;
          rdy_v[d]   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
          start_v[d] = (cyc == mid_start_at);
        end
      end
    end
    start_v[d] = 1'b0;

    if (aborted) begin
      rdy_v[d] = 1'b1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs(d, "abort");
      check("abort_state", 32'(st0), 32'(ST_IDLE));
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("post_abort_valid", 32'(val_v[d]), 0);
      end
    end else if (!ended) begin
      check("timeout", 0, 1);
    end else begin
      check("done_cycle", done_cyc, exp_done + stalls);
      check("xfer_count", xfers, 1 + rows + cfg_dd[d]);
      check("exp_left", exp_q.size(), 0);
      check("busy_after", 32'(busy_v[d]), 0);
      check("idle_data", 32'(dat_v[d]), 32'h F00);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    glyph_tab = '{
      5'h00, 5'h0A, 5'h1F, 5'h1F, 5'h0E, 5'h04, 5'h00, 5'h00,
      5'h00, 5'h0A, 5'h00, 5'h11, 5'h0E, 5'h00, 5'h00, 5'h00,
      5'h04, 5'h0E, 5'h0E, 5'h0E, 5'h1F, 5'h00, 5'h04, 5'h00,
      5'h04, 5'h0E, 5'h15, 5'h04, 5'h04, 5'h04, 5'h04, 5'h00,
      5'h04, 5'h04, 5'h04, 5'h04, 5'h15, 5'h0E, 5'h04, 5'h00,
      5'h1F, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h1F, 5'h00,
      5'h00, 5'h01, 5'h03, 5'h16, 5'h1C, 5'h08, 5'h00, 5'h00,
      5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F
    };
    rst_n   = 1'b0;
    rdy_v   = 3'b111;
    start_v = 3'b001;  // start while reset is held must be ignored
    repeat (3) @(posedge clk);
    #1;
    start_v = 3'b000;
    for (int d = 0; d < 3; d++) check_reset_outputs(d, "reset");
    check("reset_state0", 32'(st0), 32'(ST_IDLE));
    check("reset_state2", 32'(st2), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_start_busy", 32'(busy_v[0]), 0);
    check("rst_start_valid", 32'(val_v[0]), 0);

    run_load(0, 1'b0, 0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("done_held", 32'(done_v[0]), 1);
    check("done_state", 32'(st0), 32'(ST_DONE));

    run_load(0, 1'b1, 0, 0);
    run_load(0, 1'b0, 0, 40);
    run_load(1, 1'b0, 0, 0);
    run_load(1, 1'b1, 0, 0);
    run_load(2, 1'b0, 0, 0);
    run_load(0, 1'b0, 20, 0);
    run_load(0, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
